// File: rtl/jpeg_bitbuf.sv
// jpeg_bitbuf: 128-bit left-aligned bit buffer with 0xFF00 unstuffing and 64-bit look-ahead window
module jpeg_bitbuf (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  input  logic        in_scan,
  input  logic [7:0]  pc_delta,
  input  logic        align,
  output logic [63:0] window,
  output logic        bit_avali,
  output logic        eos
);
  logic [127:0] sbuf_q, sbuf_d;
  logic [7:0]   count_q, count_d, dsel, d, rem;
  logic [2:0]   ofs_q, ofs_d, ofs_neg;
  logic         ff_q, ff_d, last_q, last_d, acc, app;
  always_comb begin
    window     = sbuf_q[127:64];
    bit_avali  = (count_q >= 8'd64) | (last_q & (count_q != 8'd0));
    byte_ready = (count_q <= 8'd120) & !last_q;
    eos        = last_q & (count_q == 8'd0);
    ofs_neg    = 3'd0 - ofs_q;
    dsel       = !bit_avali ? 8'd0 : align ? {5'd0, ofs_neg} : pc_delta;
    // in tail mode the decoder may ask for more bits than remain
    d          = (last_q && dsel > count_q) ? count_q : dsel;
    acc        = byte_valid & byte_ready;
    app        = acc & !(in_scan & ff_q & (byte_in == 8'h00));
    rem        = count_q - d;
    sbuf_d     = (sbuf_q << d) | (app ? ({120'd0, byte_in} << (8'd120 - rem)) : 128'd0);
    count_d    = rem + (app ? 8'd8 : 8'd0);
    ofs_d      = ofs_q + d[2:0];
    ff_d       = !in_scan ? 1'b0 : acc ? (app & (byte_in == 8'hFF)) : ff_q;
    last_d     = last_q | (acc & byte_last);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sbuf_q  <= '0;
      count_q <= '0;
      ofs_q   <= '0;
      ff_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sbuf_q  <= sbuf_d;
      count_q <= count_d;
      ofs_q   <= ofs_d;
      ff_q    <= ff_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_jpeg_bitbuf.sv
// tb_jpeg_bitbuf: directed scenario tests for jpeg_bitbuf
module tb_jpeg_bitbuf;
  logic        clk = 0;
  logic        rst = 0;
  logic [7:0]  byte_in = 0;
  logic        byte_valid = 0;
  logic        byte_last = 0;
  logic        byte_ready;
  logic        in_scan = 0;
  logic [7:0]  pc_delta = 0;
  logic        align = 0;
  logic [63:0] window;
  logic        bit_avali;
  logic        eos;
  int tests = 0;
  int fails = 0;

  jpeg_bitbuf dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready), .in_scan(in_scan),
    .pc_delta(pc_delta), .align(align), .window(window),
    .bit_avali(bit_avali), .eos(eos)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    byte_in = b; byte_valid = 1; byte_last = last;
    step();
    byte_valid = 0; byte_last = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (window !== 64'd0) begin fails++; $display("FAIL reset_window got %h exp 0", window); end
    tests++; if (bit_avali !== 1'b0) begin fails++; $display("FAIL reset_avali got %b exp 0", bit_avali); end
    tests++; if (byte_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", byte_ready); end
    tests++; if (eos !== 1'b0) begin fails++; $display("FAIL reset_eos got %b exp 0", eos); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 7; i++) send(8'(i), 0);
    tests++; if (bit_avali !== 1'b0) begin fails++; $display("FAIL fill7_avali got %b exp 0", bit_avali); end
    send(8'h08, 0);
    tests++; if (bit_avali !== 1'b1) begin fails++; $display("FAIL fill8_avali got %b exp 1", bit_avali); end
    tests++; if (window !== 64'h0102030405060708) begin fails++; $display("FAIL fill8_window got %h exp 0102030405060708", window); end
    tests++; if (byte_ready !== 1'b1) begin fails++; $display("FAIL fill8_ready got %b exp 1", byte_ready); end
  endtask

  task automatic test_consume();
    pc_delta = 0;
    step();
    tests++; if (window !== 64'h0102030405060708) begin fails++; $display("FAIL hold_window got %h exp 0102030405060708", window); end
    pc_delta = 16;
    send(8'h09, 0);
    pc_delta = 0;
    tests++; if (window !== 64'h0304050607080900) begin fails++; $display("FAIL consume_window got %h exp 0304050607080900", window); end
    tests++; if (dut.count_q !== 8'd56) begin fails++; $display("FAIL consume_count got %0d exp 56", dut.count_q); end
    tests++; if (bit_avali !== 1'b0) begin fails++; $display("FAIL consume_avali got %b exp 0", bit_avali); end
    pc_delta = 8;
    step();
    pc_delta = 0;
    tests++; if (window !== 64'h0304050607080900) begin fails++; $display("FAIL ignore_delta_window got %h exp 0304050607080900", window); end
  endtask

  task automatic test_unstuff();
    do_reset();
    in_scan = 1;
    send(8'hFF, 0); send(8'h00, 0); send(8'h12, 0);
    tests++; if (dut.count_q !== 8'd16) begin fails++; $display("FAIL unstuff_count got %0d exp 16", dut.count_q); end
    for (int i = 1; i <= 6; i++) send(8'hA0 + 8'(i), 0);
    tests++; if (window !== 64'hFF12A1A2A3A4A5A6) begin fails++; $display("FAIL unstuff_window got %h exp FF12A1A2A3A4A5A6", window); end
    tests++; if (bit_avali !== 1'b1) begin fails++; $display("FAIL unstuff_avali got %b exp 1", bit_avali); end
    do_reset();
    in_scan = 0;
    send(8'hFF, 0); send(8'h00, 0); send(8'h12, 0);
    tests++; if (dut.count_q !== 8'd24) begin fails++; $display("FAIL noscan_count got %0d exp 24", dut.count_q); end
    for (int i = 1; i <= 5; i++) send(8'hA0 + 8'(i), 0);
    tests++; if (window !== 64'hFF0012A1A2A3A4A5) begin fails++; $display("FAIL noscan_window got %h exp FF0012A1A2A3A4A5", window); end
  endtask

  task automatic test_align();
    do_reset();
    for (int i = 1; i <= 16; i++) send(8'(i), 0);
    tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b exp 0", byte_ready); end
    pc_delta = 3;
    step();
    tests++; if (window !== 64'h0810182028303840) begin fails++; $display("FAIL delta3_window got %h exp 0810182028303840", window); end
    tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL delta3_ready got %b exp 0", byte_ready); end
    pc_delta = 9; align = 1;
    step();
    tests++; if (window !== 64'h0203040506070809) begin fails++; $display("FAIL align_window got %h exp 0203040506070809", window); end
    tests++; if (dut.ofs_q !== 3'd0) begin fails++; $display("FAIL align_ofs got %0d exp 0", dut.ofs_q); end
    tests++; if (byte_ready !== 1'b1) begin fails++; $display("FAIL align_ready got %b exp 1", byte_ready); end
    step();
    pc_delta = 0; align = 0;
    tests++; if (window !== 64'h0203040506070809) begin fails++; $display("FAIL align0_window got %h exp 0203040506070809", window); end
  endtask

  task automatic test_eos();
    do_reset();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 1);
    tests++; if (bit_avali !== 1'b1) begin fails++; $display("FAIL tail_avali got %b exp 1", bit_avali); end
    tests++; if (window !== 64'h0102030000000000) begin fails++; $display("FAIL tail_window got %h exp 0102030000000000", window); end
    tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL tail_ready got %b exp 0", byte_ready); end
    tests++; if (eos !== 1'b0) begin fails++; $display("FAIL tail_eos got %b exp 0", eos); end
    pc_delta = 64;
    step();
    pc_delta = 0;
    tests++; if (dut.count_q !== 8'd0) begin fails++; $display("FAIL drain_count got %0d exp 0", dut.count_q); end
    tests++; if (eos !== 1'b1) begin fails++; $display("FAIL drain_eos got %b exp 1", eos); end
    tests++; if (bit_avali !== 1'b0) begin fails++; $display("FAIL drain_avali got %b exp 0", bit_avali); end
    tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL drain_ready got %b exp 0", byte_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 16; i++) send(8'hB0 + 8'(i), 0);
    pc_delta = 28;
    step();
    pc_delta = 0;
    tests++; if (dut.count_q !== 8'd100) begin fails++; $display("FAIL mid_count got %0d exp 100", dut.count_q); end
    rst = 1; byte_valid = 1; byte_in = 8'hAA; pc_delta = 8;
    step();
    rst = 0; byte_valid = 0; pc_delta = 0;
    tests++; if (window !== 64'd0) begin fails++; $display("FAIL mid_window got %h exp 0", window); end
    tests++; if (bit_avali !== 1'b0) begin fails++; $display("FAIL mid_avali got %b exp 0", bit_avali); end
    tests++; if (byte_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b exp 1", byte_ready); end
    tests++; if (eos !== 1'b0) begin fails++; $display("FAIL mid_eos got %b exp 0", eos); end
    step();
    tests++; if (dut.count_q !== 8'd0) begin fails++; $display("FAIL mid_noappend got %0d exp 0", dut.count_q); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_consume();
    test_unstuff();
    test_align();
    test_eos();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
